// File: rtl/xyz_chroma_skin_classifier_pkg.sv
// Shared types and constants for the face-detection chromaticity stage.
// Includes the FSM state type, the default skin box and the datapath width helpers.
package face_det_pkg;

  typedef enum logic [1:0] {IDLE, DIV, DONE} chroma_state_t;

  // Default skin box in Q1.16: x in [0.30, 0.45], y in [0.28, 0.40].
  localparam int unsigned SKIN_X_MIN = 32'h4CCD;
  localparam int unsigned SKIN_X_MAX = 32'h7333;
  localparam int unsigned SKIN_Y_MIN = 32'h47AE;
  localparam int unsigned SKIN_Y_MAX = 32'h6666;

  function automatic int sum_width(input int data_w);
    return data_w + 2;
  endfunction

  function automatic int rem_width(input int data_w);
    return data_w + 3;
  endfunction

endpackage

// File: rtl/xyz_chroma_skin_classifier_if.sv
// Pixel-in / chromaticity-out handshake bundle for the skin classifier.
// The master is the upstream/downstream pair; the slave is the classifier.
interface xyz_chroma_skin_classifier_if #(
  parameter int DATA_W = 64,
  parameter int Q_W    = 16
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] X_in;
  logic [DATA_W-1:0] Y_in;
  logic [DATA_W-1:0] Z_in;
  logic              out_valid;
  logic              out_ready;
  logic [Q_W:0]      x_chrom;
  logic [Q_W:0]      y_chrom;
  logic              skin;
  logic              zero_sum;

  modport master (
    output in_valid, X_in, Y_in, Z_in, out_ready,
    input  in_ready, out_valid, x_chrom, y_chrom, skin, zero_sum
  );

  modport slave (
    input  in_valid, X_in, Y_in, Z_in, out_ready,
    output in_ready, out_valid, x_chrom, y_chrom, skin, zero_sum
  );

endinterface

// File: rtl/chroma_serial_divider.sv
// Bit-serial restoring divider producing floor((num << Q_W) / div) as a Q_W+1 bit quotient.
// The first quotient bit is resolved on the start edge, the remaining Q_W bits on the following cycles.
module chroma_serial_divider
  import face_det_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int Q_W    = 16
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        start,
  input  logic [DATA_W-1:0]           num,
  input  logic [sum_width(DATA_W)-1:0] div,
  output logic                        busy,
  output logic                        done,
  output logic [Q_W:0]                quo
);

  localparam int SUM_W = sum_width(DATA_W);
  localparam int REM_W = rem_width(DATA_W);
  localparam int CNT_W = $clog2(Q_W + 1);

  logic [REM_W-1:0] rem;
  logic [SUM_W-1:0] div_q;
  logic [CNT_W-1:0] cnt;
  logic [REM_W-1:0] cur_rem;
  logic [REM_W-1:0] div_ext;
  logic [REM_W-1:0] nxt_rem;
  logic [Q_W-1:0]   cur_quo;
  logic             ge;

  // Shifting the remainder instead of the numerator keeps it below 2*div, so DATA_W+3 bits suffice.
  always_comb begin
    cur_rem = start ? REM_W'(num) : rem;
    div_ext = start ? REM_W'(div) : REM_W'(div_q);
    cur_quo = start ? '0 : quo[Q_W-1:0];
    ge      = (cur_rem >= div_ext);
    nxt_rem = ge ? (cur_rem - div_ext) : cur_rem;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rem   <= '0;
      div_q <= '0;
      cnt   <= '0;
      quo   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        div_q <= div;
        rem   <= nxt_rem << 1;
        quo   <= {cur_quo, ge};
        cnt   <= '0;
        busy  <= 1'b1;
      end else if (busy) begin
        rem <= nxt_rem << 1;
        quo <= {cur_quo, ge};
        cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(Q_W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/xyz_chroma_skin_classifier.sv
// Converts one XYZ triple into chromaticity (x, y) and flags it as skin when it falls in the box.
// Both quotients share the sum divisor and run in lock-step in two serial dividers.
module xyz_chroma_skin_classifier
  import face_det_pkg::*;
#(
  parameter int          DATA_W = 64,
  parameter int          Q_W    = 16,
  parameter int unsigned X_MIN  = SKIN_X_MIN,
  parameter int unsigned X_MAX  = SKIN_X_MAX,
  parameter int unsigned Y_MIN  = SKIN_Y_MIN,
  parameter int unsigned Y_MAX  = SKIN_Y_MAX
) (
  input logic                          Clk,
  input logic                          Reset,
  xyz_chroma_skin_classifier_if.slave  bus
);

  localparam int SUM_W = sum_width(DATA_W);

  chroma_state_t    state;
  logic             zero_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [Q_W:0]     x_q;
  logic [Q_W:0]     y_q;
  logic             skin_q;
  logic             zero_sum_q;

  logic [SUM_W-1:0] sum;
  logic             sum_zero;
  logic             start;
  logic             busy_x, busy_y;
  logic             done_x, done_y;
  logic [Q_W:0]     quo_x, quo_y;
  logic             in_box;

  always_comb begin
    sum      = SUM_W'(bus.X_in) + SUM_W'(bus.Y_in) + SUM_W'(bus.Z_in);
    sum_zero = (sum == '0);
    start    = (state == IDLE) && bus.in_valid && !sum_zero;
    in_box   = (32'(quo_x) >= X_MIN) && (32'(quo_x) <= X_MAX) &&
               (32'(quo_y) >= Y_MIN) && (32'(quo_y) <= Y_MAX);
  end

  chroma_serial_divider #(.DATA_W(DATA_W), .Q_W(Q_W)) u_div_x (
    .Clk   (Clk),
    .Reset (Reset),
    .start (start),
    .num   (bus.X_in),
    .div   (sum),
    .busy  (busy_x),
    .done  (done_x),
    .quo   (quo_x)
  );

  chroma_serial_divider #(.DATA_W(DATA_W), .Q_W(Q_W)) u_div_y (
    .Clk   (Clk),
    .Reset (Reset),
    .start (start),
    .num   (bus.Y_in),
    .div   (sum),
    .busy  (busy_y),
    .done  (done_y),
    .quo   (quo_y)
  );

  // A zero sum still spends one cycle in DIV so its result appears one cycle after accept.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      skin_q      <= 1'b0;
      zero_sum_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state      <= DIV;
            zero_q     <= sum_zero;
            in_ready_q <= 1'b0;
          end
        end
        DIV: begin
          if (zero_q) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            x_q         <= '0;
            y_q         <= '0;
            skin_q      <= 1'b0;
            zero_sum_q  <= 1'b1;
          end else if (done_x && done_y && !busy_x && !busy_y) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            x_q         <= quo_x;
            y_q         <= quo_y;
            skin_q      <= in_box;
            zero_sum_q  <= 1'b0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.x_chrom   = x_q;
  assign bus.y_chrom   = y_q;
  assign bus.skin      = skin_q;
  assign bus.zero_sum  = zero_sum_q;

endmodule
